// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: default width and FSM encoding.
package div_pkg;
   localparam int DIV_WIDTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;
endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract, select.
module div_step
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic             bit_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   // rem_in < divisor keeps the difference within WIDTH bits, so the top bit is the sign.
   always_comb begin
      shifted = {rem_in, bit_in};
      trial   = shifted - {1'b0, divisor};
      q_bit   = ~trial[WIDTH];
      rem_out = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
   end
endmodule

// File: rtl/div_seq.sv
// Sequential unsigned divider: 2*WIDTH-bit dividend by WIDTH-bit divisor, one quotient bit per clock.
module div_seq
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [2*WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0]   divisor,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] quotient,
   output logic [WIDTH-1:0]   remainder,
   output logic               div_by_zero,
   output state_e             dbg_state
);
   localparam int CW = $clog2(2*WIDTH) + 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(2*WIDTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   state_e               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   dvd_q, dvd_d;
   logic [WIDTH-1:0]     dvs_q, dvs_d;
   logic [WIDTH-1:0]     rem_q, rem_d;
   logic                 dbz_q, dbz_d;
   logic                 accept;
   logic [WIDTH-1:0]     step_rem;
   logic                 step_bit;

   // Quotient bits shift into the dividend register as dividend bits shift out.
   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem_q),
      .bit_in  (dvd_q[2*WIDTH-1]),
      .divisor (dvs_q),
      .rem_out (step_rem),
      .q_bit   (step_bit)
   );

   assign accept = start && (state_q != ST_RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_RUN;
         ST_RUN:  if (cnt_q == CNT_ONE) state_d = ST_DONE;
         ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state_q == ST_RUN);
      done      = (state_q == ST_DONE);
      dbg_state = state_q;
   end

   // A zero divisor spends a single RUN cycle that forces the saturated result.
   always_comb begin
      cnt_d = cnt_q;
      dvd_d = dvd_q;
      dvs_d = dvs_q;
      rem_d = rem_q;
      dbz_d = dbz_q;
      if (accept) begin
         dvd_d = dividend;
         dvs_d = divisor;
         rem_d = '0;
         dbz_d = (divisor == '0);
         cnt_d = (divisor == '0) ? CNT_ONE : CNT_FULL;
      end else if (state_q == ST_RUN) begin
         cnt_d = cnt_q - CNT_ONE;
         if (dbz_q) begin
            dvd_d = '1;
            rem_d = '0;
         end else begin
            dvd_d = {dvd_q[2*WIDTH-2:0], step_bit};
            rem_d = step_rem;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         dvd_q <= '0;
         dvs_q <= '0;
         rem_q <= '0;
         dbz_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         dvd_q <= dvd_d;
         dvs_q <= dvs_d;
         rem_q <= rem_d;
         dbz_q <= dbz_d;
      end
   end

   assign quotient    = dvd_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;
endmodule
